// File: rtl/pipe_flow_ctrl_if.sv
// Pipeline flow-control bundle: hazard/cache inputs in, stall/flush/redirect out.
// slave = flow controller, master = pipeline/environment side.
interface pipe_flow_ctrl_if #(
  parameter int unsigned CNT_W = 32
);
  logic             id_jump_flag_i;
  logic [31:0]      id_jump_pc_i;
  logic             ex_btype_taken_i;
  logic [31:0]      ex_btype_pc_i;
  logic             id_load_use_flag_i;
  logic             icache_ready_i;
  logic             ex_mem_req_i;
  logic             dcache_ready_i;
  logic             fc_stall_if_o;
  logic             fc_stall_id_o;
  logic             fc_stall_ex_o;
  logic             fc_stall_mem_o;
  logic             fc_flush_id_o;
  logic             fc_flush_ex_o;
  logic             fc_redirect_o;
  logic [31:0]      fc_redirect_pc_o;
  logic [1:0]       fc_state_o;
  logic [CNT_W-1:0] fc_stall_cnt_o;

  modport slave (
    input  id_jump_flag_i, id_jump_pc_i, ex_btype_taken_i, ex_btype_pc_i,
           id_load_use_flag_i, icache_ready_i, ex_mem_req_i, dcache_ready_i,
    output fc_stall_if_o, fc_stall_id_o, fc_stall_ex_o, fc_stall_mem_o,
           fc_flush_id_o, fc_flush_ex_o, fc_redirect_o, fc_redirect_pc_o,
           fc_state_o, fc_stall_cnt_o
  );

  modport master (
    output id_jump_flag_i, id_jump_pc_i, ex_btype_taken_i, ex_btype_pc_i,
           id_load_use_flag_i, icache_ready_i, ex_mem_req_i, dcache_ready_i,
    input  fc_stall_if_o, fc_stall_id_o, fc_stall_ex_o, fc_stall_mem_o,
           fc_flush_id_o, fc_flush_ex_o, fc_redirect_o, fc_redirect_pc_o,
           fc_state_o, fc_stall_cnt_o
  );
endinterface

// File: rtl/pipe_flow_ctrl.sv
// Central stall/flush/redirect sequencer for the 5-stage core.
// Control outputs are combinational from state + inputs; state and counters are registered.
module pipe_flow_ctrl #(
  parameter int unsigned LU_STALL = 1,
  parameter int unsigned CNT_W    = 32
) (
  input logic             clk,
  input logic             rst,
  pipe_flow_ctrl_if.slave bus
);

  localparam int unsigned LU_W = 3;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DWAIT  = 2'd1,
    LUWAIT = 2'd2,
    RWAIT  = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [31:0]       pend_pc_q, pend_pc_d;
  logic              pend_q, pend_d;
  logic [LU_W-1:0]   lu_cnt_q, lu_cnt_d;
  logic [CNT_W-1:0]  stall_cnt_q;

  logic        stall_if, stall_id, stall_ex, stall_mem;
  logic        flush_id, flush_ex, redirect;
  logic [31:0] redirect_pc;
  logic        dmiss;

  assign dmiss = bus.ex_mem_req_i & ~bus.dcache_ready_i;

  // Next-state and control decode
  always_comb begin
    state_d     = state_q;
    pend_pc_d   = pend_pc_q;
    pend_d      = pend_q;
    lu_cnt_d    = lu_cnt_q;
    stall_if    = 1'b0;
    stall_id    = 1'b0;
    stall_ex    = 1'b0;
    stall_mem   = 1'b0;
    flush_id    = 1'b0;
    flush_ex    = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'd0;

    unique case (state_q)
      RUN: begin
        if (dmiss) begin
          // Frozen stages re-present any branch/jump once the miss clears
          {stall_if, stall_id, stall_ex, stall_mem} = 4'b1111;
          state_d = DWAIT;
        end else if (bus.ex_btype_taken_i) begin
          flush_id = 1'b1;
          flush_ex = 1'b1;
          if (bus.icache_ready_i) begin
            redirect    = 1'b1;
            redirect_pc = bus.ex_btype_pc_i;
          end else begin
            pend_pc_d = bus.ex_btype_pc_i;
            pend_d    = 1'b1;
            state_d   = RWAIT;
          end
        end else if (bus.id_jump_flag_i) begin
          flush_id = 1'b1;
          if (bus.icache_ready_i) begin
            redirect    = 1'b1;
            redirect_pc = bus.id_jump_pc_i;
          end else begin
            pend_pc_d = bus.id_jump_pc_i;
            pend_d    = 1'b1;
            state_d   = RWAIT;
          end
        end else if (bus.id_load_use_flag_i) begin
          stall_if = 1'b1;
          stall_id = 1'b1;
          flush_ex = 1'b1;
          if (LU_STALL > 1) begin
            lu_cnt_d = LU_W'(LU_STALL - 1);
            state_d  = LUWAIT;
          end
        end
      end

      DWAIT: begin
        if (!bus.dcache_ready_i) begin
          {stall_if, stall_id, stall_ex, stall_mem} = 4'b1111;
        end else begin
          state_d = RUN;
        end
      end

      LUWAIT: begin
        if (dmiss) begin
          {stall_if, stall_id, stall_ex, stall_mem} = 4'b1111;
        end else begin
          stall_if = 1'b1;
          stall_id = 1'b1;
          flush_ex = 1'b1;
          lu_cnt_d = lu_cnt_q - LU_W'(1);
          if (lu_cnt_q == LU_W'(1)) state_d = RUN;
        end
      end

      RWAIT: begin
        // Stale fetch is discarded each cycle until the Icache can take the new PC
        if (dmiss) begin
          {stall_if, stall_id, stall_ex, stall_mem} = 4'b1111;
        end else begin
          flush_id = 1'b1;
          stall_if = 1'b1;
          if (bus.icache_ready_i) begin
            redirect    = 1'b1;
            redirect_pc = pend_pc_q;
            pend_d      = 1'b0;
            state_d     = RUN;
          end
        end
      end

      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= RUN;
      pend_pc_q   <= 32'd0;
      pend_q      <= 1'b0;
      lu_cnt_q    <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      pend_pc_q <= pend_pc_d;
      pend_q    <= pend_d;
      lu_cnt_q  <= lu_cnt_d;
      if (stall_if) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
    end
  end

  assign bus.fc_stall_if_o    = stall_if;
  assign bus.fc_stall_id_o    = stall_id;
  assign bus.fc_stall_ex_o    = stall_ex;
  assign bus.fc_stall_mem_o   = stall_mem;
  assign bus.fc_flush_id_o    = flush_id;
  assign bus.fc_flush_ex_o    = flush_ex;
  assign bus.fc_redirect_o    = redirect;
  assign bus.fc_redirect_pc_o = redirect_pc;
  assign bus.fc_state_o       = state_q;
  assign bus.fc_stall_cnt_o   = stall_cnt_q;

endmodule

// File: tb/tb_pipe_flow_ctrl.sv
// Directed bench for pipe_flow_ctrl: one instance with LU_STALL=3/CNT_W=4, one with defaults.
module tb_pipe_flow_ctrl;

  logic clk;
  logic rst;
  int   n_assert;
  int   n_fail;

  pipe_flow_ctrl_if #(.CNT_W(4))  ba ();
  pipe_flow_ctrl_if #(.CNT_W(32)) bb ();

  pipe_flow_ctrl #(.LU_STALL(3), .CNT_W(4)) dut_a (.clk(clk), .rst(rst), .bus(ba));
  pipe_flow_ctrl dut_b (.clk(clk), .rst(rst), .bus(bb));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive instance A inputs at the falling edge; outputs settle before the next rise
  task automatic drv_a(input logic jmp, input logic [31:0] jpc, input logic br,
                       input logic [31:0] bpc, input logic lu, input logic ic,
                       input logic mreq, input logic drdy);
    @(negedge clk);
    ba.id_jump_flag_i     = jmp;
    ba.id_jump_pc_i       = jpc;
    ba.ex_btype_taken_i   = br;
    ba.ex_btype_pc_i      = bpc;
    ba.id_load_use_flag_i = lu;
    ba.icache_ready_i     = ic;
    ba.ex_mem_req_i       = mreq;
    ba.dcache_ready_i     = drdy;
    #1;
  endtask

  // Packed {stall_if, stall_id, stall_ex, stall_mem, flush_id, flush_ex, redirect}
  function automatic logic [31:0] ctl_a();
    return {25'd0, ba.fc_stall_if_o, ba.fc_stall_id_o, ba.fc_stall_ex_o, ba.fc_stall_mem_o,
            ba.fc_flush_id_o, ba.fc_flush_ex_o, ba.fc_redirect_o};
  endfunction

  function automatic logic [31:0] ctl_b();
    return {25'd0, bb.fc_stall_if_o, bb.fc_stall_id_o, bb.fc_stall_ex_o, bb.fc_stall_mem_o,
            bb.fc_flush_id_o, bb.fc_flush_ex_o, bb.fc_redirect_o};
  endfunction

  initial begin
    n_assert = 0;
    n_fail   = 0;
    rst      = 1'b1;
    ba.id_jump_flag_i = 1'b0; ba.id_jump_pc_i = '0; ba.ex_btype_taken_i = 1'b0;
    ba.ex_btype_pc_i = '0; ba.id_load_use_flag_i = 1'b0; ba.icache_ready_i = 1'b0;
    ba.ex_mem_req_i = 1'b0; ba.dcache_ready_i = 1'b0;
    bb.id_jump_flag_i = 1'b0; bb.id_jump_pc_i = '0; bb.ex_btype_taken_i = 1'b0;
    bb.ex_btype_pc_i = '0; bb.id_load_use_flag_i = 1'b0; bb.icache_ready_i = 1'b0;
    bb.ex_mem_req_i = 1'b0; bb.dcache_ready_i = 1'b0;

    repeat (2) @(negedge clk);
    chk("reset_state", 32'(ba.fc_state_o), 32'd0);
    chk("reset_ctl", ctl_a(), 32'h00);
    chk("reset_cnt", 32'(ba.fc_stall_cnt_o), 32'd0);
    rst = 1'b0;

    // Taken branch with Icache ready: immediate redirect
    drv_a(0, 0, 1, 32'h40, 0, 1, 0, 0);
    chk("br_ctl", ctl_a(), 32'b0000_111);
    chk("br_pc", ba.fc_redirect_pc_o, 32'h40);
    drv_a(0, 0, 0, 0, 0, 1, 0, 0);
    chk("br_state", 32'(ba.fc_state_o), 32'd0);
    chk("br_after_ctl", ctl_a(), 32'h00);

    // Jump while Icache busy 3 cycles; redirect on 4th
    drv_a(1, 32'h80, 0, 0, 0, 0, 0, 0);
    chk("jmp_c1_ctl", ctl_a(), 32'b0000_100);
    drv_a(0, 0, 0, 0, 0, 0, 0, 0);
    chk("jmp_c2_state", 32'(ba.fc_state_o), 32'd3);
    chk("jmp_c2_ctl", ctl_a(), 32'b1000_100);
    drv_a(1, 32'h999, 0, 0, 0, 0, 0, 0);
    chk("jmp_c3_ctl", ctl_a(), 32'b1000_100);
    drv_a(0, 0, 0, 0, 0, 1, 0, 0);
    chk("jmp_c4_ctl", ctl_a(), 32'b1000_101);
    chk("jmp_c4_pc", ba.fc_redirect_pc_o, 32'h80);
    drv_a(0, 0, 0, 0, 0, 1, 0, 0);
    chk("jmp_c5_state", 32'(ba.fc_state_o), 32'd0);
    chk("jmp_c5_ctl", ctl_a(), 32'h00);
    chk("jmp_cnt", 32'(ba.fc_stall_cnt_o), 32'd3);

    // Dcache miss 5 cycles with a branch held; branch acted on after release
    for (int i = 0; i < 5; i++) begin
      drv_a(0, 0, 1, 32'h200, 0, 1, 1, 0);
      chk($sformatf("dm_c%0d_ctl", i + 1), ctl_a(), 32'b1111_000);
      chk($sformatf("dm_c%0d_state", i + 1), 32'(ba.fc_state_o), (i == 0) ? 32'd0 : 32'd1);
    end
    drv_a(0, 0, 1, 32'h200, 0, 1, 1, 1);
    chk("dm_rel_ctl", ctl_a(), 32'h00);
    chk("dm_rel_state", 32'(ba.fc_state_o), 32'd1);
    drv_a(0, 0, 1, 32'h200, 0, 1, 0, 0);
    chk("dm_br_ctl", ctl_a(), 32'b0000_111);
    chk("dm_br_pc", ba.fc_redirect_pc_o, 32'h200);
    chk("dm_cnt", 32'(ba.fc_stall_cnt_o), 32'd8);

    // Load-use with LU_STALL=3
    drv_a(0, 0, 0, 0, 1, 1, 0, 0);
    chk("lu_c1_ctl", ctl_a(), 32'b1100_010);
    chk("lu_c1_state", 32'(ba.fc_state_o), 32'd0);
    drv_a(0, 0, 0, 0, 0, 1, 0, 0);
    chk("lu_c2_ctl", ctl_a(), 32'b1100_010);
    chk("lu_c2_state", 32'(ba.fc_state_o), 32'd2);
    drv_a(0, 0, 0, 0, 0, 1, 0, 0);
    chk("lu_c3_ctl", ctl_a(), 32'b1100_010);
    chk("lu_c3_state", 32'(ba.fc_state_o), 32'd2);
    drv_a(0, 0, 0, 0, 0, 1, 0, 0);
    chk("lu_c4_ctl", ctl_a(), 32'h00);
    chk("lu_c4_state", 32'(ba.fc_state_o), 32'd0);
    chk("lu_cnt", 32'(ba.fc_stall_cnt_o), 32'd11);

    // Reset while in RWAIT with pending 0x100
    drv_a(1, 32'h100, 0, 0, 0, 0, 0, 0);
    drv_a(0, 0, 0, 0, 0, 0, 0, 0);
    chk("rw_state", 32'(ba.fc_state_o), 32'd3);
    ba.icache_ready_i = 1'b1;
    rst = 1'b1;
    #1;
    chk("rst_state", 32'(ba.fc_state_o), 32'd0);
    chk("rst_cnt", 32'(ba.fc_stall_cnt_o), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drv_a(0, 0, 0, 0, 0, 1, 0, 0);
      chk($sformatf("rst_noredir_%0d", i), ctl_a(), 32'h00);
    end

    // 17 stalled cycles wrap the 4-bit counter to 1
    for (int i = 0; i < 17; i++) drv_a(0, 0, 0, 0, 0, 1, 1, 0);
    chk("wrap_ctl", ctl_a(), 32'b1111_000);
    drv_a(0, 0, 0, 0, 0, 1, 0, 1);
    chk("wrap_cnt", 32'(ba.fc_stall_cnt_o), 32'd1);

    // Default instance: single-cycle load-use stays in RUN
    @(negedge clk);
    bb.id_load_use_flag_i = 1'b1;
    #1;
    chk("b_lu_ctl", ctl_b(), 32'b1100_010);
    @(negedge clk);
    bb.id_load_use_flag_i = 1'b0;
    #1;
    chk("b_lu_state", 32'(bb.fc_state_o), 32'd0);
    chk("b_lu_after", ctl_b(), 32'h00);
    chk("b_cnt", bb.fc_stall_cnt_o, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
